// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DIV_ITERS  = 32;
    localparam int unsigned DIV_CNT_W  = 6;
    localparam int unsigned MUL_CNT_W  = 3;
    localparam logic [XLEN-1:0] DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } mdstate_t;

endpackage

// File: rtl/div_radix2_iter.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle for DIV_ITERS cycles.
module div_radix2_iter
    import hilo_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done_c
);

    logic [DIV_CNT_W-1:0] step_cnt;
    logic                 running;
    logic [XLEN-1:0]      dvsr;
    logic [XLEN:0]        shifted;
    logic                 fits;

    // Quotient register doubles as the dividend shift register.
    assign shifted = {remainder, quotient[XLEN-1]};
    assign fits    = shifted >= {1'b0, dvsr};
    assign done_c  = running && (step_cnt == DIV_CNT_W'(DIV_ITERS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt  <= '0;
            running   <= 1'b0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (clear) begin
            step_cnt <= '0;
            running  <= 1'b0;
        end else if (start) begin
            step_cnt  <= '0;
            running   <= 1'b1;
            dvsr      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (running) begin
            remainder <= fits ? XLEN'(shifted - {1'b0, dvsr}) : shifted[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], fits};
            step_cnt  <= step_cnt + DIV_CNT_W'(1);
            if (done_c) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// E-stage HI/LO sequencer: multi-cycle multiply, iterative divide, MTHI/MTLO, one write per op.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  muldiv_op_t        op,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic              flush,
    input  logic [2*XLEN-1:0] hilo_cur,
    output logic              stall,
    output logic              hilo_we,
    output logic [2*XLEN-1:0] hilo_wdata
);

    mdstate_t state, state_nxt;

    logic [MUL_CNT_W-1:0] mul_cnt;
    logic [2*XLEN-1:0]    result;
    logic                 is_div_q, q_neg, r_neg, div_zero;
    logic [XLEN-1:0]      a_raw;

    logic                 is_mul_c, is_div_c, accept_c;
    logic [XLEN-1:0]      a_mag_c, b_mag_c;
    logic [2*XLEN-1:0]    product_c, done_data_c;
    logic [XLEN-1:0]      uq, ur, q_fix_c, r_fix_c;
    logic                 div_done_c;

    assign is_mul_c = (op == MULT) || (op == MULTU);
    assign is_div_c = (op == DIV) || (op == DIVU);
    assign accept_c = (state == IDLE) && op_valid && !flush && (is_mul_c || is_div_c);

    assign a_mag_c = (op == DIV && src_a[XLEN-1]) ? -src_a : src_a;
    assign b_mag_c = (op == DIV && src_b[XLEN-1]) ? -src_b : src_b;

    // Both operands widened to 64 bits so the product is computed at full width.
    assign product_c = (op == MULT)
        ? $signed({{XLEN{src_a[XLEN-1]}}, src_a}) * $signed({{XLEN{src_b[XLEN-1]}}, src_b})
        : {{XLEN{1'b0}}, src_a} * {{XLEN{1'b0}}, src_b};

    div_radix2_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept_c && is_div_c),
        .clear     (flush),
        .dividend  (a_mag_c),
        .divisor   (b_mag_c),
        .quotient  (uq),
        .remainder (ur),
        .done_c    (div_done_c)
    );

    assign q_fix_c     = q_neg ? -uq : uq;
    assign r_fix_c     = r_neg ? -ur : ur;
    assign done_data_c = !is_div_q ? result
                       : div_zero ? {a_raw, DIVZERO_LO}
                       : {r_fix_c, q_fix_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mul_cnt  <= '0;
            result   <= '0;
            is_div_q <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
        end else begin
            state <= state_nxt;
            if (accept_c) begin
                is_div_q <= is_div_c;
                if (is_mul_c) begin
                    result  <= product_c;
                    mul_cnt <= MUL_CNT_W'(MUL_CYCLES - 1);
                end else begin
                    q_neg    <= (op == DIV) && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                    r_neg    <= (op == DIV) && src_a[XLEN-1];
                    div_zero <= (src_b == '0);
                    a_raw    <= src_a;
                end
            end else if (state == MUL_RUN && mul_cnt != '0) begin
                mul_cnt <= mul_cnt - MUL_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        hilo_we    = 1'b0;
        hilo_wdata = '0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    stall = 1'b1;
                    if (is_div_c)             state_nxt = DIV_RUN;
                    else if (MUL_CYCLES == 1) state_nxt = DONE;
                    else                      state_nxt = MUL_RUN;
                end else if (op_valid && !flush && op == MTHI) begin
                    hilo_we    = 1'b1;
                    hilo_wdata = {src_a, hilo_cur[XLEN-1:0]};
                end else if (op_valid && !flush && op == MTLO) begin
                    hilo_we    = 1'b1;
                    hilo_wdata = {hilo_cur[2*XLEN-1:XLEN], src_a};
                end
            end
            MUL_RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    if (mul_cnt == MUL_CNT_W'(1)) state_nxt = DONE;
                end
            end
            DIV_RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    if (div_done_c) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (!flush) begin
                    hilo_we    = 1'b1;
                    hilo_wdata = done_data_c;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs drop with reset, not at the next edge.
        if (rst) begin
            stall      = 1'b0;
            hilo_we    = 1'b0;
            hilo_wdata = '0;
        end
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Execute-stage sequencer for the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and runs the multi-cycle multiply or the iterative radix-2 divide.
- Stalls the pipeline while busy, then issues exactly one 64-bit write (we + data) to the HI/LO register.
- Sits between E-stage decode/operand muxes and the hilo register; hilo_cur is fed back from that register's output.

Parameters:
- MUL_CYCLES, 2: total stall cycles for MULT/MULTU, including the accept cycle; legal range 1..8.
- DIV_ITERS, 32: divider iterations, one quotient bit per cycle; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  E-stage instruction is a HI/LO op and is not bubbled
- op  in  3  muldiv_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- src_a  in  32  rs operand; dividend / multiplicand / MTHI/MTLO source
- src_b  in  32  rt operand; divisor / multiplier
- flush  in  1  kill the E-stage instruction (exception or redirect)
- hilo_cur  in  64  current HI/LO value {HI, LO}
- stall  out  1  hold the E stage and everything upstream
- hilo_we  out  1  one-cycle write enable to the HI/LO register
- hilo_wdata  out  64  {HI, LO} write data

Behaviour:
- States: IDLE, MUL_RUN, DIV_RUN, DONE. Reset forces IDLE, counter 0, result 0, stall 0, hilo_we 0, hilo_wdata 0.
- **Accept rule.** An op is accepted only in IDLE with op_valid=1, flush=0 and op in {MULT, MULTU, DIV, DIVU}. The accept cycle is T.
- **Stall (combinational).** stall = (IDLE & accept) | MUL_RUN | DIV_RUN. stall is 0 in DONE.
- **MULT/MULTU.**
  - At T: register the 64-bit signed or unsigned product.
  - MUL_RUN counts MUL_CYCLES-1 cycles; with MUL_CYCLES=1, go straight from IDLE to DONE.
  - DONE occurs at T+MUL_CYCLES.
- **DIV/DIVU.**
  - At T: latch operand magnitudes (DIV takes absolute values), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]).
  - DIV_RUN runs 32 cycles, T+1..T+32, one restoring shift-subtract step per cycle.
  - DONE occurs at T+33. Results are sign-corrected there.
  - Result layout: HI = remainder, LO = quotient.
  - DIV -2^31 / -1: LO = 0x80000000, HI = 0 (natural wrap).
- **Divide by zero.** Latency stays the same, 33 stall cycles. Result: LO = 0xFFFFFFFF, HI = src_a as latched at T.
- **DONE.** hilo_we = 1 and hilo_wdata = result for exactly one cycle, then next state is IDLE. The instruction leaves E at the end of this cycle. No new op is accepted in DONE.
- **MTHI/MTLO.** Single cycle, no stall, no state change.
  - In IDLE with op_valid & !flush: hilo_we = 1.
  - MTHI: wdata = {src_a, hilo_cur[31:0]}.
  - MTLO: wdata = {hilo_cur[63:32], src_a}.
- **hilo_we when not writing.** hilo_we = 0 in all other cases; hilo_wdata is don't-care but must be X-free.
- **Flush.**
  - In MUL_RUN or DIV_RUN: abort, next state IDLE, no write; stall drops in the same cycle (combinational from flush).
  - In DONE: the write is suppressed (hilo_we = 0).
  - In IDLE: nothing is accepted.
- **Input stability.** op, src_a and src_b are ignored after T; the controller holds its own copies.
- **Reset.** Asserted mid-operation: immediate return to IDLE, outputs go to 0 asynchronously, no write.
- **Back-to-back ops.** A MULT/DIV presented in the cycle after DONE is accepted normally. A later MFHI/MFLO observes the new value through the hilo register's next-cycle output or the existing M-stage forward path.

Decomposition:
- Shared package hilo_pkg holds:
  - muldiv_op_t (3-bit enum)
  - mdstate_t
  - constants DIV_ITERS = 32 and DIVZERO_LO = 32'hFFFF_FFFF
- One natural sub-module, div_radix2_iter:
  - Inputs: magnitudes, start, clear.
  - Outputs: unsigned quotient/remainder, done after 32 steps.
  - Sign correction and the FSM stay in hilo_muldiv_ctrl.

Test Plan:
1. **MULT.** MULT a=0xFFFFFFFE(-2), b=3, MUL_CYCLES=2 -> stall high at T and T+1; hilo_we pulse at T+2 with wdata=0xFFFFFFFF_FFFFFFFA.
2. **MULTU.** MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> wdata=0xFFFFFFFE_00000001; DIVU a=100, b=7 -> write at T+33, HI=2, LO=14.
3. **DIV signs and wrap.** DIV a=-7 (0xFFFFFFF9), b=2 -> HI=0xFFFFFFFF(-1), LO=0xFFFFFFFD(-3); DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. **Divide by zero.** DIVU a=0x1234, b=0 -> 33 stall cycles, then HI=0x00001234, LO=0xFFFFFFFF.
5. **Flush and reset.** Flush at T+10 of a DIV -> stall low that cycle, no hilo_we ever, next MULT accepted the following cycle. rst pulse mid-DIV -> all outputs 0 immediately, IDLE afterwards.
6. **MTHI/MTLO.** hilo_cur=0xAAAAAAAA_BBBBBBBB: MTHI src_a=0x11 -> same-cycle we, wdata=0x00000011_BBBBBBBB, stall 0. MTLO with flush=1 -> no write.
